// File: rtl/bus_arb_pkg.sv
// +--------------------------------------------------------------------------+
// | bus_arb_pkg : shared types, widths and the destination-ID decoder for     |
// |               the round-robin broadcast-bus arbiter.                      |
// | Revision    : 1.0                                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

package bus_arb_pkg;

  localparam int ID_W      = 8;
  localparam int MAX_PKT_W = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PUSH = 2'd2
  } arb_state_e;

  // Packets are zero-extended to MAX_PKT_W; msb is the packet's top bit index.
  function automatic logic [ID_W-1:0] dest_id(
    input logic [MAX_PKT_W-1:0] pkt,
    input logic [7:0]           msb
  );
    return pkt[msb -: ID_W];
  endfunction

endpackage

`default_nettype wire

// File: rtl/bus_rr_arbiter_if.sv
// +--------------------------------------------------------------------------+
// | bus_rr_arbiter_if : FIFO-side handshake and shared bus of the arbiter.    |
// |                     master = arbiter side, slave = driver/FIFO side.      |
// | Revision          : 1.0                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

interface bus_rr_arbiter_if #(
  parameter int DRVRS   = 4,
  parameter int PCKG_SZ = 16
) ();

  localparam int IDX_W = $clog2(DRVRS);

  logic [DRVRS-1:0]              pndng;
  logic [DRVRS-1:0][PCKG_SZ-1:0] D_pop;
  logic [DRVRS-1:0]              pop;
  logic [DRVRS-1:0]              push;
  logic [PCKG_SZ-1:0]            D_push;
  logic [IDX_W-1:0]              gnt_id;
  logic                          busy;

  modport master (
    input  pndng, D_pop,
    output pop, push, D_push, gnt_id, busy
  );

  modport slave (
    output pndng, D_pop,
    input  pop, push, D_push, gnt_id, busy
  );

endinterface

`default_nettype wire

// File: rtl/rr_picker.sv
// +--------------------------------------------------------------------------+
// | rr_picker : combinational rotate-priority selector; returns the first     |
// |             requester after ptr, wrapping at DRVRS-1 -> 0.                |
// | Revision  : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module rr_picker #(
  parameter int DRVRS = 4,
  parameter int IDX_W = $clog2(DRVRS)
) (
  input  logic [DRVRS-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] gnt,
  output logic             valid
);

  localparam logic [IDX_W:0] N_W = (IDX_W+1)'(DRVRS);

  logic [IDX_W:0] cand;
  logic           found;

  // One extra bit keeps ptr+k from overflowing before the modulo fold.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= DRVRS; k++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= N_W) begin
        cand = cand - N_W;
      end
      if (!found && req[cand[IDX_W-1:0]]) begin
        gnt   = cand[IDX_W-1:0];
        found = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

`default_nettype wire

// File: rtl/bus_rr_arbiter.sv
// +--------------------------------------------------------------------------+
// | bus_rr_arbiter : round-robin scheduler sharing one broadcast bus among    |
// |                  DRVRS FIFO-backed requesters (IDLE -> POP -> PUSH).      |
// |                  Define BUS_ARB_ERR_EN to add the err invalid-ID pulse.   |
// | Revision       : 1.0                                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module bus_rr_arbiter
  import bus_arb_pkg::*;
#(
  parameter int              DRVRS     = 4,
  parameter int              PCKG_SZ   = 16,
  parameter logic [ID_W-1:0] BROADCAST = {ID_W{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  bus_rr_arbiter_if.master bus
`ifdef BUS_ARB_ERR_EN
  ,
  output logic             err
`endif
);

  localparam int              IDX_W = $clog2(DRVRS);
  localparam logic [ID_W-1:0] N_ID  = ID_W'(DRVRS);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   gnt_q, gnt_d;
  logic [PCKG_SZ-1:0] hold_q, hold_d;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_vld;
  logic [ID_W-1:0]    dest;
  logic               dest_uni;
  logic               dest_bc;
  logic [DRVRS-1:0]   pop_w;
  logic [DRVRS-1:0]   push_w;

  rr_picker #(
    .DRVRS (DRVRS),
    .IDX_W (IDX_W)
  ) u_picker (
    .req   (bus.pndng),
    .ptr   (ptr_q),
    .gnt   (pick_idx),
    .valid (pick_vld)
  );

  assign dest     = dest_id(MAX_PKT_W'(hold_q), 8'(PCKG_SZ - 1));
  assign dest_uni = (dest < N_ID);
  assign dest_bc  = (dest == BROADCAST);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    hold_d  = hold_q;
    pop_w   = '0;
    push_w  = '0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d   = pick_idx;
          ptr_d   = pick_idx;
          state_d = POP;
        end
      end
      POP: begin
        pop_w[gnt_q] = 1'b1;
        hold_d       = bus.D_pop[gnt_q];
        state_d      = PUSH;
      end
      PUSH: begin
        // Unicast wins over broadcast so a loopback to g is honoured.
        if (dest_uni) begin
          push_w[dest[IDX_W-1:0]] = 1'b1;
        end else if (dest_bc) begin
          push_w        = '1;
          push_w[gnt_q] = 1'b0;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= IDX_W'(DRVRS - 1);
      gnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.pop    = pop_w;
  assign bus.push   = push_w;
  assign bus.D_push = hold_q;
  assign bus.gnt_id = gnt_q;
  assign bus.busy   = (state_q != IDLE);

`ifdef BUS_ARB_ERR_EN
  assign err = (state_q == PUSH) && !dest_uni && !dest_bc;
`endif

  // A FIFO must not withdraw its head while it is being popped.
  a_pop_pending: assert property (
    @(posedge clk) disable iff (!reset) (state_q == POP) |-> bus.pndng[gnt_q]
  );

endmodule

`default_nettype wire

// File: tb/tb_bus_rr_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_bus_rr_arbiter : self-checking bench with behavioural FIFO/arbiter     |
// |                     model and directed scenarios.                         |
// | Revision          : 1.0                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_bus_rr_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  bus_rr_arbiter_if #(.DRVRS(N), .PCKG_SZ(W)) bus ();

`ifdef BUS_ARB_ERR_EN
  logic err;
`endif

  bus_rr_arbiter #(
    .DRVRS   (N),
    .PCKG_SZ (W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef BUS_ARB_ERR_EN
    ,
    .err   (err)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] fifo_q [N][$];
  logic [W-1:0] mdl_q  [N][$];
  logic [N-1:0] pop_s = '0;
  int           grant_log [$];

  int           m_phase = 0;
  int           m_last  = N - 1;
  int           m_gnt   = 0;
  logic [W-1:0] m_pkt   = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      bus.pndng[i] = (fifo_q[i].size() != 0);
      bus.D_pop[i] = (fifo_q[i].size() != 0) ? fifo_q[i][0] : '0;
    end
  endtask

  task automatic load(input int i, input logic [W-1:0] p);
    fifo_q[i].push_back(p);
    mdl_q[i].push_back(p);
    refresh();
  endtask

  // Driver-side FIFOs react to the DUT's pop pulses.
  always @(negedge clk) pop_s = bus.pop;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (reset && pop_s[i] && fifo_q[i].size() != 0) begin
        void'(fifo_q[i].pop_front());
      end
    end
    refresh();
  end

  // Reference: phase 0 = waiting, 1 = popping, 2 = pushing.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase = 0;
      m_last  = N - 1;
      m_gnt   = 0;
      m_pkt   = '0;
    end else begin
      case (m_phase)
        0: begin
          for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (m_last + k) % N;
            if (m_phase == 0 && mdl_q[idx].size() != 0) begin
              m_gnt   = idx;
              m_last  = idx;
              m_phase = 1;
            end
          end
        end
        1: begin
          m_pkt   = mdl_q[m_gnt].pop_front();
          m_phase = 2;
        end
        default: m_phase = 0;
      endcase
    end
  end

  function automatic logic [N-1:0] exp_push();
    logic [7:0]   id;
    logic [N-1:0] one;
    one = 1;
    id  = m_pkt[W-1 -: 8];
    if (m_phase != 2) return '0;
    if (id < 8'(N)) return one << id;
    if (id == 8'hFF) return ~(one << m_gnt);
    return '0;
  endfunction

  always @(negedge clk) begin
    chk("pop",    32'(bus.pop),    (m_phase == 1) ? (32'(1) << m_gnt) : 32'(0));
    chk("push",   32'(bus.push),   32'(exp_push()));
    chk("D_push", 32'(bus.D_push), 32'(m_pkt));
    chk("busy",   32'(bus.busy),   32'(m_phase != 0));
    chk("gnt_id", 32'(bus.gnt_id), 32'(m_gnt));
`ifdef BUS_ARB_ERR_EN
    chk("err", 32'(err),
        32'(m_phase == 2 && m_pkt[W-1 -: 8] >= 8'(N) && m_pkt[W-1 -: 8] != 8'hFF));
`endif
    if (bus.pop != '0) grant_log.push_back(int'(bus.gnt_id));
  end

  task automatic wait_idle();
    int cnt;
    cnt = 0;
    while ((bus.busy || m_phase != 0 || fifo_q[0].size() != 0 || fifo_q[1].size() != 0 ||
            fifo_q[2].size() != 0 || fifo_q[3].size() != 0) && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout at %0t: got busy after %0d cycles, expected idle", $time, cnt);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pop"},    32'(bus.pop),    32'h0);
    chk({tag, "_push"},   32'(bus.push),   32'h0);
    chk({tag, "_dpush"},  32'(bus.D_push), 32'h0);
    chk({tag, "_busy"},   32'(bus.busy),   32'h0);
    chk({tag, "_gnt"},    32'(bus.gnt_id), 32'h0);
  endtask

  initial begin
    int exp_fair [12] = '{1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0};
    int exp_t1   [3]  = '{3, 2, 3};
    int exp_t6   [3]  = '{1, 0, 3};

    refresh();
    #1 reset = 1'b0;
    #2 chk_zero("reset");
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;

    // Unicast from driver 1 to target 2
    wait_idle();
    @(negedge clk); #1 load(1, 16'h02AB);
    @(negedge clk); #1;
    chk("uni_pop", 32'(bus.pop), 32'h2);
    chk("uni_gnt", 32'(bus.gnt_id), 32'h1);
    chk("uni_busy", 32'(bus.busy), 32'h1);
    @(negedge clk); #1;
    chk("uni_push", 32'(bus.push), 32'h4);
    chk("uni_dpush", 32'(bus.D_push), 32'h02AB);
    chk("uni_nopop", 32'(bus.pop), 32'h0);

    // Broadcast from driver 0
    wait_idle();
    @(negedge clk); #1 load(0, 16'hFF55);
    @(negedge clk); #1 chk("bc_pop", 32'(bus.pop), 32'h1);
    @(negedge clk); #1;
    chk("bc_push", 32'(bus.push), 32'hE);
    chk("bc_dpush", 32'(bus.D_push), 32'hFF55);

    // Fairness with all four FIFOs holding three packets
    wait_idle();
    grant_log.delete();
    @(negedge clk); #1;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < 3; k++) begin
        load(i, {(k == 2) ? 8'hFF : 8'((i + 1 + k) % N), 8'(i * 16 + k)});
      end
    end
    wait_idle();
    chk("fair_len", 32'(grant_log.size()), 32'd12);
    for (int j = 0; j < 12 && j < grant_log.size(); j++) begin
      chk("fair_gnt", 32'(grant_log[j]), 32'(exp_fair[j]));
    end

    // Invalid destination from driver 2
    wait_idle();
    @(negedge clk); #1 load(2, 16'h0733);
    @(negedge clk); #1 chk("inv_pop", 32'(bus.pop), 32'h4);
    @(negedge clk); #1;
    chk("inv_push", 32'(bus.push), 32'h0);
    chk("inv_dpush", 32'(bus.D_push), 32'h0733);
`ifdef BUS_ARB_ERR_EN
    chk("inv_err", 32'(err), 32'h1);
    @(negedge clk); #1 chk("inv_err_end", 32'(err), 32'h0);
`endif

    // Reset while in POP: packet stays in its FIFO and is re-served
    wait_idle();
    grant_log.delete();
    @(negedge clk); #1;
    load(2, 16'h0312);
    load(3, 16'h0045);
    @(negedge clk); #1;
    chk("rpop_pop", 32'(bus.pop), 32'h8);
    reset = 1'b0;
    #1 chk_zero("rpop");
    @(negedge clk); #1 reset = 1'b1;
    wait_idle();
    chk("rpop_len", 32'(grant_log.size()), 32'd3);
    for (int j = 0; j < 3 && j < grant_log.size(); j++) begin
      chk("rpop_gnt", 32'(grant_log[j]), 32'(exp_t1[j]));
    end

    // Reset while in PUSH (loopback packet), then drivers 0 and 3 pending
    wait_idle();
    grant_log.delete();
    @(negedge clk); #1 load(1, 16'h0111);
    @(negedge clk);
    @(negedge clk); #1;
    chk("rpush_push", 32'(bus.push), 32'h2);
    chk("rpush_dpush", 32'(bus.D_push), 32'h0111);
    reset = 1'b0;
    #1 chk_zero("rpush");
    load(0, 16'h0202);
    load(3, 16'hFF99);
    @(negedge clk); #1 reset = 1'b1;
    wait_idle();
    chk("rpush_len", 32'(grant_log.size()), 32'd3);
    for (int j = 0; j < 3 && j < grant_log.size(); j++) begin
      chk("rpush_gnt", 32'(grant_log[j]), 32'(exp_t6[j]));
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog at %0t: got no finish, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
